// File: rtl/mont_pkg.sv
// Shared constants and FSM state encoding for the Montgomery datapath stages.
package mont_pkg;

    localparam int SIZE      = 3072;
    localparam int CHUNK     = 128;
    localparam int NUM_CHUNK = SIZE / CHUNK;
    localparam int CNT_W     = $clog2(NUM_CHUNK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_SEL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sub_chunk_128.sv
// One 128-bit slice of the borrow-chained subtractor: {bout, d} = x - y - bin.
module sub_chunk_128 (
    input  logic [127:0] x,
    input  logic [127:0] y,
    input  logic         bin,
    output logic [127:0] d,
    output logic         bout
);

    logic [128:0] diff;

    // Unsigned 129-bit difference; the MSB is the outgoing borrow.
    always_comb begin
        diff = {1'b0, x} - {1'b0, y} - {128'd0, bin};
    end

    assign d    = diff[127:0];
    assign bout = diff[128];

endmodule

// File: rtl/final_reduce_3072.sv
// Final conditional subtraction res = (a >= m) ? a - m : a, computed one
// 128-bit slice per cycle so the adder never exceeds slice width.
//
// Handshake: en is a single-cycle start request, accepted only in IDLE or
// DONE (ignored while busy, never queued); a_in and m are sampled on the
// accepting edge. en_out is a single-cycle completion pulse in DONE; res and
// sub_done are valid from that cycle and hold until the next completion.
module final_reduce_3072
    import mont_pkg::*;
#(
    parameter int Size      = SIZE,
    parameter int Chunk     = CHUNK,
    parameter int Num_chunk = NUM_CHUNK,
    parameter int Cnt_w     = CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [Size-1:0] a_in,
    input  logic [Size-1:0] m,
    output logic            busy,
    output logic [Size-1:0] res,
    output logic            sub_done,
    output logic            en_out
);

    // Bit offset of the current slice: cnt * Chunk with Chunk a power of two.
    localparam int Sh_w  = $clog2(Chunk);
    localparam int Off_w = Cnt_w + Sh_w;

    state_t            state;
    state_t            state_nxt;
    logic [Cnt_w-1:0]  cnt;
    logic              borrow;
    logic [Size-1:0]   reg_a;
    logic [Size-1:0]   reg_m;
    logic [Size-1:0]   reg_d;
    logic [Off_w-1:0]  base;
    logic              last;
    logic              load;
    logic [Chunk-1:0]  slice_d;
    logic              slice_bout;

    assign base = {cnt, {Sh_w{1'b0}}};
    assign last = (cnt == Cnt_w'(Num_chunk - 1));
    assign load = en && ((state == ST_IDLE) || (state == ST_DONE));

    sub_chunk_128 u_sub (
        .x    (reg_a[base +: Chunk]),
        .y    (reg_m[base +: Chunk]),
        .bin  (borrow),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: walk every slice, select, then pulse completion.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en) state_nxt = ST_SUB;
            ST_SUB:  if (last) state_nxt = ST_SEL;
            ST_SEL:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = en ? ST_SUB : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy   = 1'b0;
        en_out = 1'b0;
        case (state)
            ST_SUB:  busy   = 1'b1;
            ST_SEL:  busy   = 1'b1;
            ST_DONE: en_out = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, slice-serial subtraction and final result selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a    <= '0;
            reg_m    <= '0;
            reg_d    <= '0;
            cnt      <= '0;
            borrow   <= 1'b0;
            res      <= '0;
            sub_done <= 1'b0;
        end else begin
            if (load) begin
                reg_a  <= a_in;
                reg_m  <= m;
                cnt    <= '0;
                borrow <= 1'b0;
            end else if (state == ST_SUB) begin
                reg_d[base +: Chunk] <= slice_d;
                borrow               <= slice_bout;
                if (!last) begin
                    cnt <= cnt + 1'b1;
                end
            end
            // A borrow out of the top slice means a < m: keep a unchanged.
            if (state == ST_SEL) begin
                res      <= borrow ? reg_a : reg_d;
                sub_done <= ~borrow;
            end
        end
    end

endmodule

// File: tb/tb_final_reduce_3072.sv
// Directed bench for final_reduce_3072: reset, latency, boundary operands,
// ignored/back-to-back starts, mid-job reset and randomized residues.
module tb_final_reduce_3072;

    localparam int W = 3072;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] m = '0;
    logic         busy;
    logic [W-1:0] res;
    logic         sub_done;
    logic         en_out;

    int errors = 0;
    int checks = 0;

    final_reduce_3072 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .a_in     (a_in),
        .m        (m),
        .busy     (busy),
        .res      (res),
        .sub_done (sub_done),
        .en_out   (en_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed hi=%0h lo=%0h expected hi=%0h lo=%0h",
                   tag, obs[W-1 -: 64], obs[63:0], exp[W-1 -: 64], exp[63:0]);
        end
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Present operands with en for one edge; returns #1 after the accepting edge.
    task automatic start_job(input logic [W-1:0] a, input logic [W-1:0] mm);
        a_in = a;
        m    = mm;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en   = 1'b0;
    endtask

    // Count cycles (accepting edge = cycle 1) until en_out, bounded.
    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (en_out !== 1'b1 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] mm,
                       input logic [W-1:0] exp_res, input logic exp_sd);
        int c;
        start_job(a, mm);
        wait_done(1, c);
        check({tag, " latency"}, W'(c), W'(26));
        check({tag, " res"}, res, exp_res);
        check({tag, " sub_done"}, W'(sub_done), W'(exp_sd));
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] ones;
    logic [W-1:0] big;
    logic [W-1:0] p128;
    int           c;
    int           pulses;

    initial begin
        ones = '1;
        big  = (W'(1) << 3071) + W'(1);
        p128 = W'(1) << 128;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", W'(busy), '0);
        check("rst en_out", W'(en_out), '0);
        check("rst res", res, '0);
        check("rst sub_done", W'(sub_done), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed boundary operands.
        run("a5_m7", W'(5), W'(7), W'(5), 1'b0);
        run("a_eq_m", big, big, '0, 1'b1);
        run("m1_a2p128", p128, W'(1), p128 - W'(1), 1'b1);
        run("top_a_lt_m", ones - W'(6), ones - W'(2), ones - W'(6), 1'b0);
        run("top_a_gt_m", ones, ones - W'(2), W'(2), 1'b1);
        run("a10_m3", W'(10), W'(3), W'(7), 1'b1);

        // en during SUB is ignored; en in DONE restarts back-to-back.
        start_job(p128, W'(1));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        a_in = W'(100);
        m    = W'(1);
        en   = 1'b1;
        @(posedge clk);
        #1;
        en   = 1'b0;
        check("ign busy", W'(busy), W'(1));
        wait_done(5, c);
        check("ign latency", W'(c), W'(26));
        check("ign res", res, p128 - W'(1));
        check("ign sub_done", W'(sub_done), W'(1));
        check("done busy", W'(busy), '0);
        start_job(W'(10), W'(3));
        check("b2b busy", W'(busy), W'(1));
        check("b2b en_out", W'(en_out), '0);
        wait_done(1, c);
        check("b2b latency", W'(c), W'(26));
        check("b2b res", res, W'(7));
        check("b2b sub_done", W'(sub_done), W'(1));
        @(posedge clk);
        #1;

        // Reset mid-job: outputs clear and the lost job never completes.
        start_job(W'(5), W'(7));
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst busy", W'(busy), '0);
        check("mid_rst en_out", W'(en_out), '0);
        check("mid_rst res", res, '0);
        check("mid_rst sub_done", W'(sub_done), '0);
        a_in = W'(9);
        m    = W'(4);
        en   = 1'b1;
        @(posedge clk);
        #1;
        en   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (en_out === 1'b1) pulses++;
        end
        check("mid_rst no en_out", W'(pulses), '0);
        check("mid_rst idle", W'(busy), '0);
        run("post_rst", W'(9), W'(4), W'(5), 1'b1);

        // Random residues: a = x or x + m with x < m, a < 2^W.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] mm;
            logic [W-1:0] x;
            logic [W-1:0] a;
            logic [W:0]   sum;
            logic         want;
            mm = rand_wide();
            if ($urandom_range(0, 3) == 0) mm[W-1:200] = '0;
            if (mm == '0) mm = W'(1);
            x    = rand_wide() % mm;
            want = 1'($urandom_range(0, 1));
            sum  = {1'b0, x} + {1'b0, mm};
            if (want && !sum[W]) begin
                a = sum[W-1:0];
            end else begin
                a    = x;
                want = 1'b0;
            end
            run("rand", a, mm, x, want);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
